motor_drive_ramp: RTL and testbench

Converts the 5-bit motor command produced by the robot FSM into per-wheel PWM and direction signals for the dual H-bridge on GPIO. Duty is slew-limited, and every direction reversal passes through zero duty and a dead-time interval. The block sits between the FSM's `motor_state` output and the GPIO pin drivers, inside the motor path.

---
 rtl/motor_pkg.sv | 23 ++
 rtl/motor_channel.sv | 111 +++++++++++
 rtl/motor_drive_ramp.sv | 111 +++++++++++
 tb/tb_motor_drive_ramp.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared motor command bit positions and the per-wheel state encoding.
package motor_pkg;

  localparam int CMD_FWD   = 0;
  localparam int CMD_REV   = 1;
  localparam int CMD_LEFT  = 2;
  localparam int CMD_RIGHT = 3;
  localparam int CMD_SLOW  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    BRAKE,
    DEAD
  } wheel_state_t;

  // True when more than one motion bit is set.
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: slew-limited duty FSM with brake/dead-time reversal and a
// period-latched PWM comparator.
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD_CYCLES = 2500,
  parameter int DEAD_CYCLES       = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ramp_tick,
  input  logic        pwm_wrap,
  input  logic [15:0] pwm_cnt,
  input  logic        tgt_dir,
  input  logic [7:0]  tgt_duty,
  output logic        pwm,
  output logic        dir,
  output logic        busy
);

  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_CYCLES - 1);
  localparam logic [15:0]    PERIOD16  = 16'(PWM_PERIOD_CYCLES);

  wheel_state_t   state_q, state_d;
  logic [7:0]     duty_q, duty_d;
  logic           dir_q, dir_d;
  logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
  logic [15:0]    cmp_q, cmp_d;
  logic           pwm_q, pwm_d;
  logic           dir_ok;
  logic [23:0]    prod;

  // A zero-duty target carries no direction: the wheel keeps its own.
  assign dir_ok = (tgt_duty == 8'd0) || (tgt_dir == dir_q);
  assign prod   = 24'(duty_q) * 24'(PERIOD16);

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    cmp_d      = cmp_q;
    if (pwm_wrap) cmp_d = prod[23:8];
    pwm_d = (pwm_cnt < cmp_q) && (duty_q != 8'd0);

    case (state_q)
      IDLE: begin
        if (tgt_duty != 8'd0) state_d = RAMP;
      end
      RAMP: begin
        if (!dir_ok) begin
          state_d = BRAKE;
        end else if (duty_q == tgt_duty) begin
          state_d = (duty_q == 8'd0) ? IDLE : HOLD;
        end else if (ramp_tick) begin
          duty_d = (duty_q < tgt_duty) ? duty_q + 8'd1 : duty_q - 8'd1;
        end
      end
      HOLD: begin
        if (!dir_ok || duty_q != tgt_duty) state_d = RAMP;
      end
      BRAKE: begin
        if (dir_ok) begin
          state_d = RAMP;
        end else if (duty_q == 8'd0) begin
          state_d    = DEAD;
          dead_cnt_d = '0;
        end else if (ramp_tick) begin
          duty_d = duty_q - 8'd1;
        end
      end
      DEAD: begin
        if (tgt_duty == 8'd0) begin
          state_d = IDLE;
        end else if (dir_ok) begin
          state_d = RAMP;
        end else if (dead_cnt_q == DEAD_LAST) begin
          dir_d   = ~dir_q;
          state_d = RAMP;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      duty_q     <= 8'd0;
      dir_q      <= 1'b1;
      dead_cnt_q <= '0;
      cmp_q      <= 16'd0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
      cmp_q      <= cmp_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign dir  = dir_q;
  assign busy = (state_q != IDLE) && (state_q != HOLD);

endmodule

// File: rtl/motor_drive_ramp.sv
// Motor command to dual H-bridge PWM/direction, with shared ramp prescaler
// and PWM period counter.
module motor_drive_ramp
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD_CYCLES = 2500,
  parameter int RAMP_STEP_CYCLES  = 50000,
  parameter int DEAD_CYCLES       = 50000,
  parameter int FULL_DUTY         = 200,
  parameter int SLOW_DUTY         = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] motor_cmd,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic       busy,
  output logic       cmd_err
);

  localparam int PSW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(RAMP_STEP_CYCLES - 1);
  localparam logic [15:0]    PWM_LAST   = 16'(PWM_PERIOD_CYCLES - 1);
  localparam logic [7:0]     FULL8      = 8'(FULL_DUTY);
  localparam logic [7:0]     SLOW8      = 8'(SLOW_DUTY);

  logic [4:0]     cmd_q, cmd_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic           tick_q, tick_d;
  logic [15:0]    pwm_cnt_q, pwm_cnt_d;
  logic           pwm_wrap;
  logic           l_tgt_dir, r_tgt_dir;
  logic [7:0]     tgt_duty, motion_duty;
  logic           l_busy, r_busy;

  assign pwm_wrap    = (pwm_cnt_q == PWM_LAST);
  assign motion_duty = cmd_q[CMD_SLOW] ? SLOW8 : FULL8;

  always_comb begin
    cmd_d     = motor_cmd;
    presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    tick_d    = (presc_q == PRESC_LAST);
    pwm_cnt_d = pwm_wrap ? 16'd0 : pwm_cnt_q + 16'd1;
  end

  // Stop and multi-bit commands fall through with zero duty.
  always_comb begin
    l_tgt_dir = 1'b1;
    r_tgt_dir = 1'b1;
    tgt_duty  = 8'd0;
    case (cmd_q[3:0])
      4'b0001: begin l_tgt_dir = 1'b1; r_tgt_dir = 1'b1; tgt_duty = motion_duty; end
      4'b0010: begin l_tgt_dir = 1'b0; r_tgt_dir = 1'b0; tgt_duty = motion_duty; end
      4'b0100: begin l_tgt_dir = 1'b0; r_tgt_dir = 1'b1; tgt_duty = motion_duty; end
      4'b1000: begin l_tgt_dir = 1'b1; r_tgt_dir = 1'b0; tgt_duty = motion_duty; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q     <= 5'd0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= 16'd0;
    end else begin
      cmd_q     <= cmd_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  motor_channel #(
    .PWM_PERIOD_CYCLES(PWM_PERIOD_CYCLES),
    .DEAD_CYCLES      (DEAD_CYCLES)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .ramp_tick(tick_q),
    .pwm_wrap (pwm_wrap),
    .pwm_cnt  (pwm_cnt_q),
    .tgt_dir  (l_tgt_dir),
    .tgt_duty (tgt_duty),
    .pwm      (left_pwm),
    .dir      (left_dir),
    .busy     (l_busy)
  );

  motor_channel #(
    .PWM_PERIOD_CYCLES(PWM_PERIOD_CYCLES),
    .DEAD_CYCLES      (DEAD_CYCLES)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .ramp_tick(tick_q),
    .pwm_wrap (pwm_wrap),
    .pwm_cnt  (pwm_cnt_q),
    .tgt_dir  (r_tgt_dir),
    .tgt_duty (tgt_duty),
    .pwm      (right_pwm),
    .dir      (right_dir),
    .busy     (r_busy)
  );

  assign busy    = l_busy | r_busy;
  assign cmd_err = multi_hot(cmd_q[3:0]);

endmodule

// File: tb/tb_motor_drive_ramp.sv
// Directed bench for motor_drive_ramp with short period/ramp/dead parameters.
module tb_motor_drive_ramp;
  import motor_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] motor_cmd;
  logic       left_pwm, right_pwm, left_dir, right_dir, busy, cmd_err;

  int tests  = 0;
  int failed = 0;

  motor_drive_ramp #(
    .PWM_PERIOD_CYCLES(256),
    .RAMP_STEP_CYCLES (4),
    .DEAD_CYCLES      (8),
    .FULL_DUTY        (200),
    .SLOW_DUTY        (100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .motor_cmd(motor_cmd),
    .left_pwm (left_pwm),
    .right_pwm(right_pwm),
    .left_dir (left_dir),
    .right_dir(right_dir),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_settled"}, 32'(busy), 0);
  endtask

  task automatic count_high(output int nl, output int nr);
    nl = 0;
    nr = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (left_pwm) nl++;
      if (right_pwm) nr++;
    end
  endtask

  initial begin
    int cyc, nl, nr, zero_run, i;
    logic flag_a, flag_b, flag_c;
    logic [7:0] prev_duty;
    logic prev_dir;

    // Reset held with a motion command pending
    reset = 1'b0;
    motor_cmd = 5'b00001;
    repeat (5) @(negedge clk);
    check("rst_left_pwm", 32'(left_pwm), 0);
    check("rst_right_pwm", 32'(right_pwm), 0);
    check("rst_left_dir", 32'(left_dir), 1);
    check("rst_right_dir", 32'(right_dir), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("ramp_busy_rise", 32'(busy), 1);
    wait_done("ramp_up", cyc);
    cyc += 3;
    check("ramp_up_time", 32'((cyc >= 798) && (cyc <= 806)), 1);
    check("ramp_up_duty_l", 32'(dut.u_left.duty_q), 200);
    check("ramp_up_duty_r", 32'(dut.u_right.duty_q), 200);
    repeat (300) @(negedge clk);
    count_high(nl, nr);
    check("full_pwm_l", 32'(nl), 200);
    check("full_pwm_r", 32'(nr), 200);

    // Slow: ramp down to 100, direction untouched
    motor_cmd = 5'b10001;
    flag_a = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!left_dir || !right_dir) flag_a = 1'b1;
    end
    check("slow_time", 32'((cyc >= 396) && (cyc <= 410)), 1);
    check("slow_dir_stable", 32'(flag_a), 0);
    check("slow_duty_l", 32'(dut.u_left.duty_q), 100);
    repeat (300) @(negedge clk);
    count_high(nl, nr);
    check("slow_pwm_l", 32'(nl), 100);
    check("slow_pwm_r", 32'(nr), 100);

    motor_cmd = 5'b00001;
    wait_done("back_full", cyc);
    check("back_full_duty", 32'(dut.u_left.duty_q), 200);

    // Reversal from duty 200
    motor_cmd = 5'b00010;
    flag_a = 1'b0;   // flip seen
    flag_b = 1'b0;   // pwm high during sustained zero duty
    flag_c = 1'b0;   // dir changed while duty nonzero
    zero_run = 0;
    prev_duty = dut.u_left.duty_q;
    prev_dir = left_dir;
    i = 0;
    while ((i < 4000) && !(flag_a && !busy)) begin
      @(negedge clk);
      i++;
      if (dut.u_left.duty_q == 8'd0 && left_dir && !flag_a) zero_run++;
      if (dut.u_left.duty_q == 8'd0 && prev_duty == 8'd0 && left_pwm) flag_b = 1'b1;
      if (left_dir != prev_dir) begin
        flag_a = 1'b1;
        if (prev_duty != 8'd0 || dut.u_left.duty_q != 8'd0) flag_c = 1'b1;
      end
      prev_duty = dut.u_left.duty_q;
      prev_dir = left_dir;
    end
    check("rev_flip_seen", 32'(flag_a), 1);
    check("rev_dead_len", 32'((zero_run >= 8) && (zero_run <= 10)), 1);
    check("rev_pwm_dead_low", 32'(flag_b), 0);
    check("rev_dir_at_zero", 32'(flag_c), 0);
    check("rev_left_dir", 32'(left_dir), 0);
    check("rev_right_dir", 32'(right_dir), 0);
    check("rev_duty_l", 32'(dut.u_left.duty_q), 200);
    check("rev_duty_r", 32'(dut.u_right.duty_q), 200);

    motor_cmd = 5'b00001;
    wait_done("fwd_again", cyc);
    check("fwd_again_dir_l", 32'(left_dir), 1);

    // Spin left
    motor_cmd = 5'b00100;
    wait_done("spin", cyc);
    check("spin_left_dir", 32'(left_dir), 0);
    check("spin_right_dir", 32'(right_dir), 1);
    check("spin_duty_l", 32'(dut.u_left.duty_q), 200);
    check("spin_duty_r", 32'(dut.u_right.duty_q), 200);

    motor_cmd = 5'b00001;
    wait_done("unspin", cyc);
    check("unspin_dir_l", 32'(left_dir), 1);

    // Spin again, abort during the left wheel's dead time
    motor_cmd = 5'b00100;
    i = 0;
    while ((i < 2000) && (dut.u_left.state_q != DEAD)) begin
      @(negedge clk);
      i++;
    end
    check("abort_reached_dead", 32'(dut.u_left.state_q == DEAD), 1);
    motor_cmd = 5'b00001;
    flag_a = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      cyc++;
      if (!left_dir) flag_a = 1'b1;
    end
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!left_dir) flag_a = 1'b1;
    end
    check("abort_no_flip", 32'(flag_a), 0);
    check("abort_left_dir", 32'(left_dir), 1);
    check("abort_duty_l", 32'(dut.u_left.duty_q), 200);

    // Invalid command
    motor_cmd = 5'b00011;
    #1;
    check("inv_err_before_edge", 32'(cmd_err), 0);
    @(negedge clk);
    check("inv_err_set", 32'(cmd_err), 1);
    wait_done("inv", cyc);
    check("inv_duty_l", 32'(dut.u_left.duty_q), 0);
    check("inv_duty_r", 32'(dut.u_right.duty_q), 0);
    check("inv_dir_l", 32'(left_dir), 1);
    check("inv_dir_r", 32'(right_dir), 1);
    check("inv_state_idle", 32'(dut.u_left.state_q == IDLE), 1);
    repeat (300) @(negedge clk);
    count_high(nl, nr);
    check("inv_pwm_l", 32'(nl), 0);
    check("inv_err_held", 32'(cmd_err), 1);
    motor_cmd = 5'b00000;
    @(negedge clk);
    check("inv_err_clear", 32'(cmd_err), 0);

    // Reset in the middle of a ramp
    motor_cmd = 5'b00001;
    i = 0;
    while ((i < 2000) && (dut.u_left.duty_q != 8'd57)) begin
      @(negedge clk);
      i++;
    end
    check("mid_reached_57", 32'(dut.u_left.duty_q), 57);
    reset = 1'b0;
    #1;
    check("mid_rst_pwm_l", 32'(left_pwm), 0);
    check("mid_rst_pwm_r", 32'(right_pwm), 0);
    check("mid_rst_duty", 32'(dut.u_left.duty_q), 0);
    check("mid_rst_busy", 32'(busy), 0);
    motor_cmd = 5'b00000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_idle_busy", 32'(busy), 0);
    check("mid_idle_state", 32'(dut.u_right.state_q == IDLE), 1);
    count_high(nl, nr);
    check("mid_idle_pwm", 32'(nl + nr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
